// File: rtl/mem_stage.sv
// Memory-access stage: byte-lane store/load alignment, wait-state handshake FSM and MEM/WB register.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (flag misaligned accesses instead of aligning them down).
//
//   state | meaning
//   IDLE  | no access outstanding; a ready-on-first-cycle access completes here
//   WAIT  | access issued, memory not yet ready; upstream held by StallM
module mem_stage #(
  parameter int XLEN   = 64,
  parameter int STRB_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              MemToRegM,
  input  logic              MemReadM,
  input  logic              Mem_ReadM,
  input  logic [1:0]        MemTypeM,
  input  logic [4:0]        RD_M,
  input  logic [XLEN-1:0]   WriteDataM,
  input  logic [XLEN-1:0]   ALU_ResultM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [STRB_W-1:0] dmem_wstrb,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ready,
  output logic              StallM,
  output logic              RegWriteW,
  output logic              MemToRegW,
  output logic [4:0]        RD_W,
  output logic [XLEN-1:0]   ALU_ResultW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic              MisalignW,
  output logic [31:0]       StallCount
);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;

  logic [2:0]        off, off_eff, size_mask;
  logic              misaligned, mem_op, is_load;
  logic [XLEN-1:0]   wrep, lane, load_ext;
  logic [STRB_W-1:0] strb_base;

  assign off     = ALU_ResultM[2:0];
  assign is_load = MemReadM & ~MemWriteM;

  always_comb begin
    size_mask = 3'd0;
    strb_base = 8'h01;
    wrep      = {8{WriteDataM[7:0]}};
    case (MemTypeM)
      2'b00: begin size_mask = 3'd0; strb_base = 8'h01; wrep = {8{WriteDataM[7:0]}};  end
      2'b01: begin size_mask = 3'd1; strb_base = 8'h03; wrep = {4{WriteDataM[15:0]}}; end
      2'b10: begin size_mask = 3'd3; strb_base = 8'h0F; wrep = {2{WriteDataM[31:0]}}; end
      default: begin size_mask = 3'd7; strb_base = 8'hFF; wrep = WriteDataM;          end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = (MemReadM | MemWriteM) & (|(off & size_mask));
  assign off_eff    = off;
`else
  assign misaligned = 1'b0;
  assign off_eff    = off & ~size_mask;
`endif

  assign mem_op = (MemReadM | MemWriteM) & ~misaligned;

  // Request/stall are gated by reset so an abandoned access drops at once.
  assign dmem_req   = reset & ((state == WAIT) | mem_op);
  assign StallM     = dmem_req & ~dmem_ready;
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = {ALU_ResultM[XLEN-1:3], 3'b000};
  assign dmem_wdata = wrep << {off_eff, 3'b000};
  assign dmem_wstrb = MemWriteM ? (strb_base << off_eff) : '0;

  assign lane = dmem_rdata >> {off_eff, 3'b000};

  always_comb begin
    load_ext = lane;
    case (MemTypeM)
      2'b00: load_ext = Mem_ReadM ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      2'b01: load_ext = Mem_ReadM ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      2'b10: load_ext = Mem_ReadM ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      RegWriteW   <= 1'b0;
      MemToRegW   <= 1'b0;
      RD_W        <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      MisalignW   <= 1'b0;
      StallCount  <= '0;
    end else begin
      case (state)
        IDLE: if (mem_op && !dmem_ready) state <= WAIT;
        WAIT: if (dmem_ready)            state <= IDLE;
        default:                         state <= IDLE;
      endcase

      RD_W        <= RD_M;
      ALU_ResultW <= ALU_ResultM;
      if (StallM) begin
        RegWriteW <= 1'b0;
        MemToRegW <= 1'b0;
        MisalignW <= 1'b0;
        ReadDataW <= '0;
      end else begin
        RegWriteW <= RegWriteM & ~misaligned;
        MemToRegW <= MemToRegM;
        MisalignW <= misaligned;
        ReadDataW <= (is_load && mem_op) ? load_ext : '0;
      end

      if (StallM && (StallCount != 32'hFFFF_FFFF))
        StallCount <= StallCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage (default build): directed test-plan steps plus random ops vs a byte-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM, MemWriteM, MemToRegM, MemReadM, Mem_ReadM;
  logic [1:0]  MemTypeM;
  logic [4:0]  RD_M;
  logic [63:0] WriteDataM, ALU_ResultM;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ready;
  logic        StallM, RegWriteW, MemToRegW, MisalignW;
  logic [4:0]  RD_W;
  logic [63:0] ALU_ResultW, ReadDataW;
  logic [31:0] StallCount;

  int unsigned nvec = 0;
  int unsigned nmis = 0;
  int unsigned stall_model = 0;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemToRegM(MemToRegM),
    .MemReadM(MemReadM), .Mem_ReadM(Mem_ReadM), .MemTypeM(MemTypeM), .RD_M(RD_M),
    .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .StallM(StallM), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .RD_W(RD_W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .MisalignW(MisalignW),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] t);
    return 1 << t;
  endfunction

  // Without the trap feature, a misaligned offset is rounded down to the access size.
  function automatic int eff_off(input logic [63:0] a, input logic [1:0] t);
    int o;
    o = int'(a[2:0]);
    return o - (o % nbytes(t));
  endfunction

  function automatic logic [7:0] exp_strb(input logic [63:0] a, input logic [1:0] t);
    logic [7:0] s;
    int o;
    s = '0;
    o = eff_off(a, t);
    for (int i = 0; i < 8; i++) s[i] = (i >= o) && (i < o + nbytes(t));
    return s;
  endfunction

  function automatic logic [63:0] byte_mask(input logic [7:0] s);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [63:0] exp_wdata(input logic [63:0] a, input logic [1:0] t, input logic [63:0] wd);
    logic [63:0] v;
    int o;
    v = '0;
    o = eff_off(a, t);
    for (int j = 0; j < nbytes(t); j++) v[8*(o+j) +: 8] = wd[8*j +: 8];
    return v;
  endfunction

  function automatic logic [63:0] exp_load(input logic [63:0] rd, input logic [63:0] a,
                                           input logic [1:0] t, input logic uns);
    logic [63:0] v;
    int o, n;
    v = '0;
    o = eff_off(a, t);
    n = nbytes(t);
    for (int j = 0; j < n; j++) v[8*j +: 8] = rd[8*(o+j) +: 8];
    if (!uns && n < 8 && v[8*n-1])
      for (int j = n; j < 8; j++) v[8*j +: 8] = 8'hFF;
    return v;
  endfunction

  // kind: 0 = ALU op, 1 = load, 2 = store. waitn = cycles dmem_ready stays low.
  task automatic run_op(input string tag, input int kind, input logic [1:0] t, input logic [63:0] a,
                        input logic [63:0] wd, input logic uns, input logic [4:0] rd,
                        input logic regw, input logic m2r, input int waitn_in, input logic [63:0] rdata);
    int waitn;
    waitn       = (kind == 0) ? 0 : waitn_in;
    RegWriteM   = regw;
    MemWriteM   = (kind == 2);
    MemReadM    = (kind == 1);
    MemToRegM   = m2r;
    Mem_ReadM   = uns;
    MemTypeM    = t;
    RD_M        = rd;
    WriteDataM  = wd;
    ALU_ResultM = a;
    dmem_rdata  = rdata;
    for (int k = 0; k <= waitn; k++) begin
      dmem_ready = (k == waitn);
      #3;
      chk({tag, ".req"},   dmem_req, (kind != 0));
      chk({tag, ".stall"}, StallM,   (kind != 0) && (k < waitn));
      if (k == 0 && kind != 0) begin
        chk({tag, ".addr"}, dmem_addr, {a[63:3], 3'b000});
        chk({tag, ".we"},   dmem_we,   (kind == 2));
        if (kind == 2) begin
          chk({tag, ".wstrb"}, dmem_wstrb, exp_strb(a, t));
          chk({tag, ".wdata"}, dmem_wdata & byte_mask(exp_strb(a, t)), exp_wdata(a, t, wd));
        end
      end
      @(posedge clk); #1;
      if (k < waitn) chk({tag, ".bubble"}, RegWriteW, 1'b0);
    end
    stall_model += waitn;
    chk({tag, ".regw"},  RegWriteW,   regw);
    chk({tag, ".m2r"},   MemToRegW,   m2r);
    chk({tag, ".rd"},    RD_W,        rd);
    chk({tag, ".alu"},   ALU_ResultW, a);
    chk({tag, ".rdata"}, ReadDataW,   (kind == 1) ? exp_load(rdata, a, t, uns) : 64'd0);
    chk({tag, ".mis"},   MisalignW,   1'b0);
    chk({tag, ".scnt"},  StallCount,  64'(stall_model));
  endtask

  initial begin
    reset = 1'b0;
    {RegWriteM, MemWriteM, MemToRegM, MemReadM, Mem_ReadM} = '0;
    MemTypeM = '0; RD_M = '0; WriteDataM = '0; ALU_ResultM = '0;
    dmem_rdata = '0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req",   dmem_req,    1'b0);
    chk("rst.stall", StallM,      1'b0);
    chk("rst.regw",  RegWriteW,   1'b0);
    chk("rst.alu",   ALU_ResultW, 64'd0);
    chk("rst.scnt",  StallCount,  64'd0);
    reset = 1'b1;

    run_op("nonmem", 0, 2'b11, 64'd30, 64'd0, 1'b0, 5'd5, 1'b1, 1'b0, 0, 64'd0);
    run_op("st_b",   2, 2'b00, 64'h1003, 64'hAB, 1'b0, 5'd0, 1'b0, 1'b0, 0, 64'd0);
    chk("st_b.lane", dmem_wdata[31:24], 64'hAB);
    run_op("ld_h_s", 1, 2'b01, 64'h2006, 64'd0, 1'b0, 5'd7, 1'b1, 1'b1, 3, 64'h8001_0000_0000_0000);
    chk("ld_h_s.val", ReadDataW, 64'hFFFF_FFFF_FFFF_8001);
    chk("ld_h_s.cnt", StallCount, 64'd3);
    run_op("ld_h_u", 1, 2'b01, 64'h2006, 64'd0, 1'b1, 5'd7, 1'b1, 1'b1, 3, 64'h8001_0000_0000_0000);
    chk("ld_h_u.val", ReadDataW, 64'h0000_0000_0000_8001);
    run_op("ld_w_mis", 1, 2'b10, 64'h1002, 64'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1, 64'h1122_3344_5566_7788);
    chk("ld_w_mis.val", ReadDataW, 64'h0000_0000_5566_7788);
    run_op("st_w_mis", 2, 2'b10, 64'h1002, 64'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 1'b0, 0, 64'd0);
    run_op("ld_d",   1, 2'b11, 64'h3008, 64'd0, 1'b1, 5'd3, 1'b1, 1'b1, 2, 64'hF000_0000_0000_0001);

    // Reset while WAIT: access is abandoned and the FSM returns to IDLE.
    RegWriteM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; MemTypeM = 2'b10;
    ALU_ResultM = 64'h4000; RD_M = 5'd4; dmem_ready = 1'b0;
    @(posedge clk); #1;
    chk("rstw.inwait", StallM, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rstw.req",   dmem_req,    1'b0);
    chk("rstw.stall", StallM,      1'b0);
    chk("rstw.regw",  RegWriteW,   1'b0);
    chk("rstw.rd",    RD_W,        5'd0);
    chk("rstw.rdata", ReadDataW,   64'd0);
    chk("rstw.scnt",  StallCount,  64'd0);
    stall_model = 0;
    {RegWriteM, MemWriteM, MemToRegM, MemReadM, Mem_ReadM} = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    #3;
    chk("rstw.idle", dmem_req, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      run_op("rnd", kind, 2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the 64-bit RISC-V pipeline, directly downstream of the execute stage. Consumes the EX/MEM control and data bundle and performs loads and stores through a handshaked data-memory port. Handles byte lanes, sign/zero extension and a wait-state FSM that stalls upstream. Registers the MEM/WB bundle for the write-back stage.

Parameters:
XLEN, 64, datapath width; only 64 is supported.
STRB_W, 8, byte strobes per memory beat (XLEN/8).

Ports:
clk  input  1  clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
RegWriteM  input  1  register write enable from EX/MEM.
MemWriteM  input  1  store.
MemToRegM  input  1  write-back selects load data.
MemReadM  input  1  load.
Mem_ReadM  input  1  load is unsigned (zero-extend); ignored for stores.
MemTypeM  input  2  size: 00 byte, 01 half, 10 word, 11 double.
RD_M  input  5  destination register.
WriteDataM  input  64  store data (forwarded rs2).
ALU_ResultM  input  64  effective address, or ALU result.
dmem_req  output  1  memory request valid.
dmem_we  output  1  1 = store.
dmem_addr  output  64  doubleword-aligned address {ALU_ResultM[63:3],3'b000}.
dmem_wdata  output  64  lane-positioned store data.
dmem_wstrb  output  8  byte enables.
dmem_rdata  input  64  load data, valid when dmem_ready.
dmem_ready  input  1  access completes this cycle.
StallM  output  1  freeze PC, IF/ID, ID/EX and EX/MEM.
RegWriteW  output  1  registered.
MemToRegW  output  1  registered.
RD_W  output  5  registered.
ALU_ResultW  output  64  registered.
ReadDataW  output  64  registered, extended load data.
MisalignW  output  1  registered misaligned-access flag.
StallCount  output  32  saturating count of StallM cycles.

Behaviour:
- Reset: all registered outputs are 0, FSM is IDLE, StallCount is 0. dmem_req and StallM are 0 while reset is asserted. Asserting reset mid-access abandons the access; no write-back occurs.
- mem_op = (MemReadM | MemWriteM) & ~misaligned. If MemReadM and MemWriteM are both 1, treat the access as a store.
- off = ALU_ResultM[2:0]. A size is misaligned when off is not a multiple of the size.
- FSM states:
  - IDLE: with mem_op, dmem_req=1 combinationally.
    - If dmem_ready is high the same cycle: zero-wait completion; MEM/WB captures; stay IDLE; StallM=0.
    - Otherwise go to WAIT with StallM=1.
  - WAIT: dmem_req=1 and StallM=1. Inputs are held stable by the stall.
    - When dmem_ready: capture MEM/WB, StallM=0, go to IDLE.
- While StallM=1, MEM/WB loads a bubble: RegWriteW=0, MemToRegW=0, MisalignW=0.
- Non-memory ops never stall; MEM/WB captures every cycle.
- Store lanes:
  - dmem_wdata = size-replicated data shifted left by off*8.
  - dmem_wstrb = mask of 1, 3, 15 or 255 shifted left by off.
  - dmem_we = MemWriteM.
- Load: lane = dmem_rdata >> (off*8). Truncate to size, then zero-extend if Mem_ReadM else sign-extend. A 64-bit load ignores Mem_ReadM.
- Non-load ops: ReadDataW captures 0.
- StallCount increments each cycle StallM=1 and saturates at 32'hFFFFFFFF.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: a misaligned access raises no dmem_req and causes no stall. MEM/WB captures MisalignW=1 with RegWriteW forced to 0.
- Undefined: misaligned is tied to 0 and MisalignW is tied to 0. off is aligned down to the size (low bits masked) and the access proceeds normally.

Test Plan:
1. Non-memory op: ALU_ResultM=30, RD_M=5, RegWriteM=1 -> next edge RegWriteW=1, RD_W=5, ALU_ResultW=30; dmem_req=0, StallM=0.
2. Zero-wait store: byte, ALU_ResultM=0x1003, WriteDataM=0xAB, dmem_ready=1 -> dmem_addr=0x1000, dmem_wstrb=8'h08, dmem_wdata[31:24]=0xAB; no stall.
3. Load with wait states: signed half at 0x2006, dmem_ready low for 3 cycles, dmem_rdata=64'h8001_0000_0000_0000 -> StallM high 3 cycles; RegWriteW=0 during the stall; then ReadDataW=64'hFFFF_FFFF_FFFF_8001 and StallCount=3.
4. Same load with Mem_ReadM=1 -> ReadDataW=64'h0000_0000_0000_8001.
5. Reset asserted during WAIT -> dmem_req and StallM drop immediately; all outputs are 0; FSM is IDLE after release.
6. With MEM_MISALIGN_TRAP_EN, word load at 0x1002 -> dmem_req=0, MisalignW=1, RegWriteW=0. Without the macro -> dmem_wstrb/lane at offset 0, normal completion.
